// File: rtl/mem_pkg.sv
// Shared encodings for the data-side memory path: access sizes, responder
// FSM states and the default memory-mapped I/O addresses.
package mem_pkg;

    localparam logic [2:0] SIZE_B = 3'b100;
    localparam logic [2:0] SIZE_H = 3'b010;
    localparam logic [2:0] SIZE_W = 3'b001;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        MERGE,
        WRITE,
        RESP
    } state_t;

    localparam logic [31:0] DEF_GPIO_ADDR  = 32'h8000_0000;
    localparam logic [31:0] DEF_CYCLE_ADDR = 32'h8000_0004;

    function automatic logic size_onehot(input logic [2:0] size);
        return (size == SIZE_B) || (size == SIZE_H) || (size == SIZE_W);
    endfunction

endpackage

// File: rtl/ram_sync.sv
// Single-port word RAM with one-cycle synchronous read and full-word write.
// Contents are never reset.
module ram_sync #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  we,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [0:(2**ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// Data-side load/store responder: services one request at a time from a word
// RAM (read-modify-write for byte/half stores) or from the GPIO / cycle registers.
module mem_responder
    import mem_pkg::*;
#(
    parameter int          ADDR_WIDTH = 10,
    parameter int          GPIO_WIDTH = 8,
    parameter logic [31:0] GPIO_ADDR  = DEF_GPIO_ADDR,
    parameter logic [31:0] CYCLE_ADDR = DEF_CYCLE_ADDR
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    input  logic                  req_write,
    input  logic [2:0]            req_size,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [GPIO_WIDTH-1:0] gpio
);

    localparam int BA_W = ADDR_WIDTH + 2;

    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  ofs,
                                                 input logic [2:0]  size);
        logic [31:0] sh;
        sh = word >> {ofs, 3'b000};
        case (size)
            SIZE_B:  return {24'd0, sh[7:0]};
            SIZE_H:  return {16'd0, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                               input logic [1:0]  ofs,
                                               input logic [2:0]  size,
                                               input logic [31:0] wd);
        logic [31:0] m;
        m = word;
        if (size == SIZE_B) begin
            case (ofs)
                2'd0: m[7:0]   = wd[7:0];
                2'd1: m[15:8]  = wd[7:0];
                2'd2: m[23:16] = wd[7:0];
                default: m[31:24] = wd[7:0];
            endcase
        end else if (size == SIZE_H) begin
            if (ofs[1]) m[31:16] = wd[15:0];
            else        m[15:0]  = wd[15:0];
        end else begin
            m = wd;
        end
        return m;
    endfunction

    state_t            state, state_next;
    logic [BA_W-1:0]   addr_p0;
    logic              write_p0;
    logic [2:0]        size_p0;
    logic [31:0]       wdata_p0;
    logic [31:0]       io_rdata_p0;
    logic              err_p0;
    logic              io_p0;
    logic [31:0]       cycle_cnt;

    logic [31:0]       ram_rdata;
    logic [31:0]       ram_wdata;
    logic              ram_we;

    logic is_h, is_w, is_gpio, is_cyc, in_ram, acc_err, accept;

    // Request decode, evaluated against the live request in the accept cycle
    assign is_h    = (req_size == SIZE_H);
    assign is_w    = (req_size == SIZE_W);
    assign is_gpio = (req_addr == GPIO_ADDR);
    assign is_cyc  = (req_addr == CYCLE_ADDR);
    assign in_ram  = ((req_addr >> BA_W) == 32'd0);
    assign acc_err = !size_onehot(req_size)
                   || (is_h && req_addr[0])
                   || (is_w && (req_addr[1:0] != 2'b00))
                   || (!in_ram && !is_gpio && !is_cyc)
                   || ((is_gpio || is_cyc) && !is_w)
                   || (is_cyc && req_write);

    assign req_ready = (state == IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_next = state;
        ram_we     = 1'b0;
        ram_wdata  = wdata_p0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = 32'd0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (acc_err || is_gpio || is_cyc) state_next = RESP;
                    else if (req_write && is_w)      state_next = WRITE;
                    else                             state_next = READ;
                end
            end
            READ: begin
                state_next = write_p0 ? MERGE : RESP;
            end
            MERGE: begin
                ram_we     = !reset;
                ram_wdata  = lane_merge(ram_rdata, addr_p0[1:0], size_p0, wdata_p0);
                state_next = RESP;
            end
            WRITE: begin
                ram_we     = !reset;
                state_next = RESP;
            end
            RESP: begin
                resp_valid = !reset;
                resp_err   = !reset && err_p0;
                if (!reset && !err_p0 && !write_p0) begin
                    resp_rdata = io_p0 ? io_rdata_p0
                                       : lane_extract(ram_rdata, addr_p0[1:0], size_p0);
                end
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cycle_cnt <= 32'd0;
            gpio      <= '0;
            err_p0    <= 1'b0;
            io_p0     <= 1'b0;
            write_p0  <= 1'b0;
        end else begin
            state     <= state_next;
            cycle_cnt <= cycle_cnt + 32'd1;
            if (accept) begin
                err_p0   <= acc_err;
                io_p0    <= is_gpio || is_cyc;
                write_p0 <= req_write;
                if (!acc_err && is_gpio && req_write) begin
                    gpio <= req_wdata[GPIO_WIDTH-1:0];
                end
            end
        end
    end

    // Request payload and I/O read value captured at accept
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_p0     <= req_addr[BA_W-1:0];
            size_p0     <= req_size;
            wdata_p0    <= req_wdata;
            io_rdata_p0 <= is_gpio ? 32'(gpio) : cycle_cnt;
        end
    end

    ram_sync #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk  (clk),
        .addr (addr_p0[BA_W-1:2]),
        .we   (ram_we),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

endmodule

// File: doc/mem_responder.md
# mem_responder

Data-side memory responder for the multi-cycle RISC-V core. It accepts one load/store request at a time over a valid/ready handshake and services it from a word-organised synchronous RAM or from two memory-mapped I/O registers: a GPIO output register and a free-running cycle counter. Partial stores use a read-modify-write sequence. Load data is returned right-aligned, so the core's sign/zero extension operates on bits [7:0] / [15:0].

## Interface
Parameters:
- ADDR_WIDTH, 10: RAM word-address bits; RAM holds 2^ADDR_WIDTH 32-bit words, i.e. byte range 0 .. 4*2^ADDR_WIDTH-1.
- GPIO_WIDTH, 8: width of the GPIO output register.
- GPIO_ADDR, 32'h8000_0000: byte address of the GPIO register.
- CYCLE_ADDR, 32'h8000_0004: byte address of the cycle counter (read-only).

Ports:
- clk  in  1  sole clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_addr  in  32  byte address.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  3  one-hot size: 3'b100 byte, 3'b010 half, 3'b001 word.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  load data, right-aligned; 0 for stores and errors.
- resp_err  out  1  qualifies resp_valid; request rejected.
- gpio  out  GPIO_WIDTH  GPIO register contents.

## Operation
- Accept occurs when req_valid && req_ready. req_ready = 1 only in IDLE. addr, write, size and wdata are latched on accept.
- The core must hold the request stable until it is accepted.
- Error conditions, checked at accept:
  - size not exactly one-hot;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - address outside RAM and not GPIO_ADDR/CYCLE_ADDR;
  - any size other than word to GPIO_ADDR or CYCLE_ADDR;
  - store to CYCLE_ADDR.
- On error: no state change anywhere; response carries resp_err=1, rdata=0.
- Load from RAM: rdata = word >> (8*addr[1:0]), masked to the access size; upper bits are zero.
- Store to RAM:
  - word: full-word write;
  - byte/half: read the word, replace the lane(s) at addr[1:0] with wdata[7:0] / wdata[15:0], then write the merged word back.
- GPIO: a word store sets gpio <= wdata[GPIO_WIDTH-1:0]; a word load returns gpio zero-extended.
- Cycle counter: 32-bit, +1 every cycle, wraps 32'hFFFF_FFFF -> 0. A load returns the value held in the accept cycle.
- States:
  - IDLE: on accept, go to RESP if error or I/O; to WRITE if word store; otherwise to READ.
  - READ: issue array read, then go to MERGE for a partial store or RESP for a load.
  - MERGE: write the merged word, then go to RESP.
  - WRITE: write the full word, then go to RESP.
  - RESP: resp_valid=1 for this cycle only, then go to IDLE.
- No response backpressure; the core must sample resp_* in the RESP cycle.

## Timing
- Response cycle relative to accept cycle T:
  - error/I/O: resp_valid at T+1;
  - load / word store: T+2;
  - partial store: T+3.
- resp_rdata and resp_err are valid only while resp_valid=1; both hold 0 otherwise.
- RAM contents become visible to a load accepted after the RESP cycle.
- req_ready rises in the cycle after RESP, so back-to-back accepts are at least latency+1 cycles apart.
- Reset values: state IDLE, req_ready=0 during reset and 1 in the first cycle after, resp_valid=0, resp_rdata=0, resp_err=0, gpio=0, counter=0. RAM is not cleared.
- Reset mid-transaction aborts it: no response is issued. A write in WRITE/MERGE coinciding with reset is not performed, because reset has priority.

## Structure
- Package mem_pkg holds:
  - size encodings SIZE_B/SIZE_H/SIZE_W (shared with the core's memory-write encoding);
  - state enum IDLE/READ/MERGE/WRITE/RESP;
  - default GPIO_ADDR/CYCLE_ADDR constants.
- Sub-module ram_sync: single-port array, 2^ADDR_WIDTH x 32, synchronous read (1 cycle), full-word write enable, no reset.
- Lane extract/merge and error decode stay inline in mem_responder.

## Test plan
- Word store 32'hDEADBEEF to 0x10, then word load from 0x10: store resp at T+2 with err=0; load resp at T+2 with rdata=32'hDEADBEEF.
- Byte store 8'h5A to 0x13 over word 32'h11223344: resp at T+3; a word load then returns 32'h5A223344, and a byte load from 0x13 returns 32'h0000005A.
- Half load from 0x11, and word store to 0x12: both give resp_err=1 at T+1, rdata=0, and the word at 0x10 is unchanged.
- Word store 32'h000000A5 to GPIO_ADDR: gpio=8'hA5 after RESP. A word load returns 32'h000000A5. A byte store to GPIO_ADDR gives err=1 and gpio stays 8'hA5.
- Two loads of CYCLE_ADDR accepted N cycles apart return values differing by exactly N. Force the counter to 32'hFFFF_FFFF: the next cycle reads 0. A store to CYCLE_ADDR gives err=1.
- Assert reset in the MERGE cycle of a byte store: no resp_valid is issued, the RAM word is unchanged, all outputs are 0, and req_ready=1 in the cycle after reset deasserts.
